// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory answering the core's data port.
// Writes land on the rising edge, reads are combinational. After reset a clear
// sequencer zeroes every word, then accesses are accepted. Saturating access
// counters and sticky error flags help bring-up.
// Optional feature macro: DMEM_PARITY_EN adds a per-word parity bit, the
// inj_par input and a live parity_err flag.
module dmem_responder #(
  parameter int DW    = 32,
  parameter int AW    = 7,
  parameter int DEPTH = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CEN,
  input  logic             WEN,
  input  logic             OEN,
  input  logic [AW-1:0]    A,
  input  logic [DW-1:0]    Data2Mem,
`ifdef DMEM_PARITY_EN
  input  logic             inj_par,
`endif
  output logic [DW-1:0]    ReadDataMem,
  output logic             ready,
  output logic             conflict,
  output logic             range_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             parity_err
);

  typedef enum logic {CLEAR, READY} state_t;

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t           state;
  logic [AW-1:0]    clr_ptr;
  logic [DW-1:0]    mem [DEPTH];

  logic in_range, acc, wr_acc, rd_acc, wr_hit, rd_hit;

  // Access decode; ready doubles as the "in READY state" qualifier.
  always_comb begin
    in_range = ({1'b0, A} < DEPTH_L);
    acc      = ready && !CEN;
    wr_acc   = acc && !WEN;
    rd_acc   = acc && !OEN;
    wr_hit   = wr_acc && in_range;
    rd_hit   = rd_acc && in_range;
  end

  // Read path: pre-edge contents, so a same-cycle write never bypasses.
  assign ReadDataMem = rd_hit ? mem[A] : '0;

  // Clear sequencer: walk clr_ptr across the array, then open for business.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == LAST) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage: zero fill during CLEAR, bus writes in READY; rst edges drop writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[clr_ptr] <= '0;
      else if (wr_hit)
        mem[A] <= Data2Mem;
    end
  end

  // Saturating access counters and sticky bring-up flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      conflict  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (rd_acc && rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
      if (wr_acc && wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
      if (wr_acc && rd_acc)        conflict  <= 1'b1;
      if ((wr_acc || rd_acc) && !in_range) range_err <= 1'b1;
    end
  end

`ifdef DMEM_PARITY_EN
  logic par_mem [DEPTH];

  // Parity store follows the data store; inj_par flips the stored bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        par_mem[clr_ptr] <= 1'b0;
      else if (wr_hit)
        par_mem[A] <= (^Data2Mem) ^ inj_par;
    end
  end

  // Sticky parity check on every in-range READY read.
  always_ff @(posedge clk) begin
    if (rst)
      parity_err <= 1'b0;
    else if (rd_hit && ((^mem[A]) != par_mem[A]))
      parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: default instance driven against a behavioural
// memory model with random traffic, plus a DEPTH=100 / CNT_W=4 instance for
// range and saturation corners.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        rst = 1'b1, cen = 1'b1, wen = 1'b1, oen = 1'b1, inj = 1'b0;
  logic [6:0]  a = '0;
  logic [31:0] din = '0, rdata;
  logic        ready, conflict, range_err, perr;
  logic [15:0] rd_cnt, wr_cnt;

  // Small instance
  logic        rst2 = 1'b1, cen2 = 1'b1, wen2 = 1'b1, oen2 = 1'b1, inj2 = 1'b0;
  logic [6:0]  a2 = '0;
  logic [31:0] din2 = '0, rdata2;
  logic        ready2, conflict2, range_err2, perr2;
  logic [3:0]  rd_cnt2, wr_cnt2;

  dmem_responder dut (
    .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .Data2Mem(din),
`ifdef DMEM_PARITY_EN
    .inj_par(inj),
`endif
    .ReadDataMem(rdata), .ready(ready), .conflict(conflict), .range_err(range_err),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .parity_err(perr));

  dmem_responder #(.DEPTH(100), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .CEN(cen2), .WEN(wen2), .OEN(oen2), .A(a2), .Data2Mem(din2),
`ifdef DMEM_PARITY_EN
    .inj_par(inj2),
`endif
    .ReadDataMem(rdata2), .ready(ready2), .conflict(conflict2), .range_err(range_err2),
    .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2), .parity_err(perr2));

  int checks = 0, failures = 0;

  // Reference model of the default instance (valid while it is READY)
  logic [31:0] mem_m [128];
  bit          par_m [128];
  int          rd_m, wr_m;
  bit          conf_m, perr_m;

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin mem_m[i] = '0; par_m[i] = 1'b0; end
    rd_m = 0; wr_m = 0; conf_m = 0; perr_m = 0;
  endtask

  task automatic drive1(input bit c, input bit w, input bit o, input logic [6:0] ad,
                        input logic [31:0] d, input bit ij);
    cen = c; wen = w; oen = o; a = ad; din = d; inj = ij;
    #1;
  endtask

  function automatic logic [31:0] exp_rd1();
    return (!cen && !oen) ? mem_m[a] : 32'h0;
  endfunction

  // Advance one edge and apply the access rules to the model.
  task automatic step1();
    @(posedge clk); #1;
    if (!cen) begin
      if (!oen) begin
`ifdef DMEM_PARITY_EN
        if ((^mem_m[a]) != par_m[a]) perr_m = 1;
`endif
        if (rd_m < 65535) rd_m++;
      end
      if (!wen) begin
        mem_m[a] = din; par_m[a] = (^din) ^ inj;
        if (wr_m < 65535) wr_m++;
      end
      if (!wen && !oen) conf_m = 1;
    end
    cen = 1; wen = 1; oen = 1; inj = 0;
  endtask

  task automatic test_reset();
    rst = 1; cen = 0; wen = 0; oen = 0; a = 7'd5; din = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, conflict, range_err, perr, rd_cnt, wr_cnt, rdata} !== '0) begin
      failures++;
      $display("FAIL reset_state ready=%b conf=%b rng=%b perr=%b rd=%0d wr=%0d rdata=%h exp all 0",
               ready, conflict, range_err, perr, rd_cnt, wr_cnt, rdata);
    end
    rst = 0;
    for (int k = 1; k <= 128; k++) begin
      cen = 0; wen = 1'($urandom); oen = 0; a = 7'($urandom); din = $urandom;
      @(posedge clk); #1;
      if (k < 128) begin
        checks++;
        if (ready !== 1'b0 || rdata !== 32'h0 || rd_cnt !== 16'h0 || wr_cnt !== 16'h0) begin
          failures++;
          $display("FAIL clear_edge%0d ready=%b rdata=%h rd=%0d wr=%0d exp 0", k, ready, rdata, rd_cnt, wr_cnt);
        end
      end
    end
    cen = 1; wen = 1; oen = 1;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_128 got=%b exp=1", ready);
    end
    model_reset();
  endtask

  task automatic test_write_read();
    drive1(0, 0, 1, 7'd5, 32'hDEAD_BEEF, 0); step1();
    drive1(0, 1, 0, 7'd5, 32'h0, 0);
    checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL write_read got=%h exp=deadbeef", rdata);
    end
    step1();
    checks++;
    if (wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin
      failures++; $display("FAIL wr_rd_cnt got wr=%0d rd=%0d exp 1/1", wr_cnt, rd_cnt);
    end
  endtask

  task automatic test_clear_all();
    for (int i = 0; i < 128; i++) begin
      if (i == 5) continue;
      drive1(0, 1, 0, 7'(i), 32'h0, 0);
      checks++;
      if (rdata !== 32'h0) begin
        failures++; $display("FAIL cleared_word%0d got=%h exp=0", i, rdata);
      end
      step1();
    end
    checks++;
    if (rd_cnt !== 16'(rd_m)) begin
      failures++; $display("FAIL sweep_rd_cnt got=%0d exp=%0d", rd_cnt, rd_m);
    end
  endtask

  task automatic test_conflict();
    drive1(0, 0, 1, 7'd9, 32'h11, 0); step1();
    checks++;
    if (conflict !== 1'b0) begin
      failures++; $display("FAIL conflict_early got=%b exp=0", conflict);
    end
    drive1(0, 0, 0, 7'd9, 32'h22, 0);
    checks++;
    if (rdata !== 32'h11) begin
      failures++; $display("FAIL conflict_read got=%h exp=11", rdata);
    end
    step1();
    checks++;
    if (conflict !== 1'b1) begin
      failures++; $display("FAIL conflict_flag got=%b exp=1", conflict);
    end
    drive1(0, 1, 0, 7'd9, 32'h0, 0);
    checks++;
    if (rdata !== 32'h22) begin
      failures++; $display("FAIL conflict_after got=%h exp=22", rdata);
    end
    step1();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive1(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
             7'($urandom_range(0, 15)), $urandom, 0);
      checks++;
      if (rdata !== exp_rd1()) begin
        failures++; $display("FAIL rand_rdata%0d a=%0d got=%h exp=%h", n, a, rdata, exp_rd1());
      end
      step1();
      checks++;
      if (rd_cnt !== 16'(rd_m) || wr_cnt !== 16'(wr_m) || conflict !== conf_m ||
          range_err !== 1'b0 || perr !== perr_m) begin
        failures++;
        $display("FAIL rand_state%0d rd=%0d/%0d wr=%0d/%0d conf=%b/%b rng=%b/0 perr=%b/%b",
                 n, rd_cnt, rd_m, wr_cnt, wr_m, conflict, conf_m, range_err, perr, perr_m);
      end
    end
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    drive1(0, 0, 1, 7'd3, 32'h1, 1); step1();
    checks++;
    if (perr !== 1'b0) begin
      failures++; $display("FAIL parity_before_read got=%b exp=0", perr);
    end
    drive1(0, 1, 0, 7'd3, 32'h0, 0); step1();
    checks++;
    if (perr !== 1'b1) begin
      failures++; $display("FAIL parity_err got=%b exp=1", perr);
    end
  endtask
`endif

  task automatic test_rst_mid();
    int edges;
    rst = 1; @(posedge clk); #1;
    rst = 0;
    repeat (50) @(posedge clk);
    #1; rst = 1; @(posedge clk); #1; rst = 0;
    edges = 0;
    while (ready !== 1'b1 && edges < 300) begin
      @(posedge clk); #1; edges++;
    end
    checks++;
    if (edges !== 128) begin
      failures++; $display("FAIL rst_mid_ready_edges got=%0d exp=128", edges);
    end
    checks++;
    if (perr !== 1'b0 || conflict !== 1'b0 || rd_cnt !== 16'h0 || wr_cnt !== 16'h0) begin
      failures++; $display("FAIL rst_mid_state perr=%b conf=%b rd=%0d wr=%0d exp 0", perr, conflict, rd_cnt, wr_cnt);
    end
    model_reset();
    foreach (mem_m[i]) if (i < 16) begin
      drive1(0, 1, 0, 7'(i), 32'h0, 0);
      checks++;
      if (rdata !== 32'h0) begin
        failures++; $display("FAIL rst_mid_cleared%0d got=%h exp=0", i, rdata);
      end
      step1();
    end
  endtask

  task automatic test_small_range_sat();
    int edges, nrd;
    rst2 = 1; @(posedge clk); #1; rst2 = 0;
    edges = 0;
    while (ready2 !== 1'b1 && edges < 300) begin
      @(posedge clk); #1; edges++;
    end
    checks++;
    if (edges !== 100) begin
      failures++; $display("FAIL small_ready_edges got=%0d exp=100", edges);
    end
    for (int i = 0; i < 100; i++) begin
      cen2 = 0; wen2 = 0; oen2 = 1; a2 = 7'(i); din2 = 32'(i * 3 + 7);
      @(posedge clk); #1;
    end
    cen2 = 1; wen2 = 1;
    checks++;
    if (wr_cnt2 !== 4'hF || range_err2 !== 1'b0) begin
      failures++; $display("FAIL small_wr_sat wr=%0d exp=15 rng=%b exp=0", wr_cnt2, range_err2);
    end
    cen2 = 0; wen2 = 0; a2 = 7'd120; din2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    cen2 = 1; wen2 = 1;
    checks++;
    if (range_err2 !== 1'b1) begin
      failures++; $display("FAIL small_range_err got=%b exp=1", range_err2);
    end
    nrd = 0;
    for (int i = 0; i < 102; i++) begin
      logic [6:0]  ad;
      logic [31:0] ex;
      ad = (i == 0) ? 7'd120 : (i == 1) ? 7'd100 : 7'(i - 2);
      ex = (ad >= 7'd100) ? 32'h0 : 32'(int'(ad) * 3 + 7);
      cen2 = 0; oen2 = 0; a2 = ad;
      #1;
      checks++;
      if (rdata2 !== ex) begin
        failures++; $display("FAIL small_read_a%0d got=%h exp=%h", ad, rdata2, ex);
      end
      @(posedge clk); #1;
      nrd++;
      checks++;
      if (rd_cnt2 !== 4'((nrd > 15) ? 15 : nrd)) begin
        failures++; $display("FAIL small_rd_sat after %0d reads got=%0d", nrd, rd_cnt2);
      end
    end
    cen2 = 1; oen2 = 1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_clear_all();
    test_conflict();
    test_random();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    test_rst_mid();
    test_small_range_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
